// File: rtl/esp32_boot_pkg.sv
// Shared constants for the ESP32 EN/GPIO0 strap sequencer.
package esp32_boot_pkg;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE       = 3'd0;
  localparam state_t ST_EN_LOW     = 3'd1;
  localparam state_t ST_STRAP_HOLD = 3'd2;
  localparam state_t ST_SETTLE     = 3'd3;
  localparam state_t ST_DONE       = 3'd4;

  localparam logic MODE_RUN  = 1'b0;
  localparam logic MODE_BOOT = 1'b1;

  // Released ESP32: EN high, GPIO0 pulled high (normal run strap).
  localparam logic IDLE_WIFI_EN    = 1'b1;
  localparam logic IDLE_WIFI_GPIO0 = 1'b1;

  // Counter width able to hold (largest phase length - 1); never below 1 bit.
  function automatic int unsigned cnt_width(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
    int unsigned m;
    int unsigned w;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    w = $clog2(m);
    return (w < 1) ? 1 : w;
  endfunction

endpackage

// File: rtl/esp32_boot_sequencer_timer.sv
// Loadable down-counter pacing each timed phase of the boot sequence.
module boot_delay_timer #(
  parameter int unsigned WIDTH = 1
) (
  input  logic             clk_25mhz,
  input  logic             rst_n,
  input  logic             load,
  input  logic             en,
  input  logic [WIDTH-1:0] load_value,
  output logic             zero
);

  logic [WIDTH-1:0] cnt_q, cnt_d;

  // Load wins over decrement; the count parks at zero instead of wrapping.
  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_value;
    end else if (en && (cnt_q != '0)) begin
      cnt_d = cnt_q - WIDTH'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign zero = (cnt_q == '0);

endmodule

// File: rtl/esp32_boot_sequencer.sv
// Drives the ESP32 EN/GPIO0 reset-strap sequence into run or bootloader mode.
//
// state         | meaning
// --------------+--------------------------------------------------------
// ST_IDLE       | ESP32 released, ready for a request
// ST_EN_LOW     | EN held low, GPIO0 at strap value (~mode)
// ST_STRAP_HOLD | EN high, GPIO0 still at strap value while ESP32 samples it
// ST_SETTLE     | EN high, GPIO0 released high, waiting for ESP32 to start
// ST_DONE       | one-cycle completion pulse
module esp32_boot_sequencer
  import esp32_boot_pkg::*;
#(
  parameter int unsigned EN_LOW_CYCLES     = 2_500_000,
  parameter int unsigned STRAP_HOLD_CYCLES = 1_250_000,
  parameter int unsigned SETTLE_CYCLES     = 250_000
) (
  input  logic clk_25mhz,
  input  logic rst_n,
  input  logic req_valid,
  input  logic req_boot,
  output logic req_ready,
  output logic busy,
  output logic done,
  output logic uart_hold,
  output logic wifi_en,
  output logic wifi_gpio0
);

  localparam int unsigned CNT_W = cnt_width(EN_LOW_CYCLES, STRAP_HOLD_CYCLES, SETTLE_CYCLES);

  localparam logic [CNT_W-1:0] EN_LOAD     = CNT_W'(EN_LOW_CYCLES - 1);
  localparam logic [CNT_W-1:0] HOLD_LOAD   = CNT_W'(STRAP_HOLD_CYCLES - 1);
  localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

  state_t           state_q, state_d;
  logic             mode_q, mode_d;
  logic             wifi_en_q, wifi_en_d;
  logic             wifi_gpio0_q, wifi_gpio0_d;
  logic             timer_load;
  logic [CNT_W-1:0] timer_load_value;
  logic             timer_zero;
  logic             timed_state;

  assign timed_state = (state_q == ST_EN_LOW) || (state_q == ST_STRAP_HOLD) ||
                       (state_q == ST_SETTLE);

  boot_delay_timer #(
    .WIDTH (CNT_W)
  ) u_timer (
    .clk_25mhz  (clk_25mhz),
    .rst_n      (rst_n),
    .load       (timer_load),
    .en         (timed_state),
    .load_value (timer_load_value),
    .zero       (timer_zero)
  );

  // Next-state logic; the timer is reloaded on every transition into a timed phase.
  always_comb begin
    state_d          = state_q;
    mode_d           = mode_q;
    timer_load       = 1'b0;
    timer_load_value = EN_LOAD;
    case (state_q)
      ST_IDLE: begin
        if (req_valid) begin
          mode_d     = req_boot;
          state_d    = ST_EN_LOW;
          timer_load = 1'b1;
        end
      end
      ST_EN_LOW: begin
        if (timer_zero) begin
          state_d          = ST_STRAP_HOLD;
          timer_load       = 1'b1;
          timer_load_value = HOLD_LOAD;
        end
      end
      ST_STRAP_HOLD: begin
        if (timer_zero) begin
          state_d          = ST_SETTLE;
          timer_load       = 1'b1;
          timer_load_value = SETTLE_LOAD;
        end
      end
      ST_SETTLE: begin
        if (timer_zero) state_d = ST_DONE;
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  // Pin values follow the state being entered so EN and GPIO0 are glitch-free registers.
  always_comb begin
    wifi_en_d    = (state_d != ST_EN_LOW);
    wifi_gpio0_d = !((mode_d == MODE_BOOT) &&
                     ((state_d == ST_EN_LOW) || (state_d == ST_STRAP_HOLD)));
  end

  // State, mode and pin registers; reset releases the ESP32 into normal run.
  always_ff @(posedge clk_25mhz or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      mode_q       <= MODE_RUN;
      wifi_en_q    <= IDLE_WIFI_EN;
      wifi_gpio0_q <= IDLE_WIFI_GPIO0;
    end else begin
      state_q      <= state_d;
      mode_q       <= mode_d;
      wifi_en_q    <= wifi_en_d;
      wifi_gpio0_q <= wifi_gpio0_d;
    end
  end

  assign req_ready  = (state_q == ST_IDLE);
  assign busy       = timed_state;
  assign done       = (state_q == ST_DONE);
  assign uart_hold  = timed_state;
  assign wifi_en    = wifi_en_q;
  assign wifi_gpio0 = wifi_gpio0_q;

endmodule

// File: tb/tb_esp32_boot_sequencer.sv
// Scoreboard bench for esp32_boot_sequencer with short phase lengths.
module tb_esp32_boot_sequencer;

  localparam int EN_L  = 4;
  localparam int HOLD  = 3;
  localparam int SET   = 2;
  localparam int TOTAL = EN_L + HOLD + SET + 2;

  logic clk       = 1'b0;
  logic rst_n     = 1'b1;
  logic req_valid = 1'b0;
  logic req_boot  = 1'b0;
  logic req_ready, busy, done, uart_hold, wifi_en, wifi_gpio0;

  typedef struct packed {
    logic en;
    logic gpio0;
    logic busy;
    logic done;
    logic ready;
  } exp_t;

  localparam exp_t IDLE_EXP = '{en: 1'b1, gpio0: 1'b1, busy: 1'b0, done: 1'b0, ready: 1'b1};

  exp_t  exp_q[$];
  int    total  = 0;
  int    bad    = 0;
  bit    mon_en = 1'b0;
  string scn    = "reset";

  esp32_boot_sequencer #(
    .EN_LOW_CYCLES     (EN_L),
    .STRAP_HOLD_CYCLES (HOLD),
    .SETTLE_CYCLES     (SET)
  ) dut (
    .clk_25mhz  (clk),
    .rst_n      (rst_n),
    .req_valid  (req_valid),
    .req_boot   (req_boot),
    .req_ready  (req_ready),
    .busy       (busy),
    .done       (done),
    .uart_hold  (uart_hold),
    .wifi_en    (wifi_en),
    .wifi_gpio0 (wifi_gpio0)
  );

  always #5 clk = ~clk;

  task automatic chk_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    if (obs !== exp) begin
      bad++;
      $display("FAIL %s got=%0d want=%0d", tag, obs, exp);
    end
  endtask

  task automatic check_all(input exp_t e);
    chk_eq({scn, ":wifi_en"},    32'(wifi_en),    32'(e.en));
    chk_eq({scn, ":wifi_gpio0"}, 32'(wifi_gpio0), 32'(e.gpio0));
    chk_eq({scn, ":busy"},       32'(busy),       32'(e.busy));
    chk_eq({scn, ":uart_hold"},  32'(uart_hold),  32'(e.busy));
    chk_eq({scn, ":done"},       32'(done),       32'(e.done));
    chk_eq({scn, ":req_ready"},  32'(req_ready),  32'(e.ready));
  endtask

  // Expected pins for cycles k+1 .. k+TOTAL after acceptance at edge k.
  task automatic push_seq(input logic boot);
    exp_t e;
    for (int i = 1; i <= TOTAL; i++) begin
      e.en    = (i > EN_L);
      e.gpio0 = !(boot && (i <= EN_L + HOLD));
      e.busy  = (i <= EN_L + HOLD + SET);
      e.done  = (i == EN_L + HOLD + SET + 1);
      e.ready = (i == TOTAL);
      exp_q.push_back(e);
    end
  endtask

  task automatic wait_drain();
    int n = 0;
    while ((exp_q.size() > 0) && (n < 100)) begin
      @(negedge clk);
      n++;
    end
    chk_eq({scn, ":drain"}, 32'(exp_q.size()), 32'd0);
  endtask

  // Per-cycle monitor: pending scoreboard entry if any, else the released/idle pins.
  always @(posedge clk) begin
    exp_t e;
    #1;
    if (mon_en) begin
      if (exp_q.size() > 0) e = exp_q.pop_front();
      else                  e = IDLE_EXP;
      check_all(e);
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout want=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    #1 rst_n = 1'b0;
    #2;
    check_all(IDLE_EXP);
    repeat (3) @(negedge clk);
    rst_n  = 1'b1;
    mon_en = 1'b1;

    scn = "idle";
    repeat (6) @(negedge clk);

    scn = "boot";
    req_valid = 1'b1;
    req_boot  = 1'b1;
    push_seq(1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    req_boot  = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);

    scn = "run";
    req_valid = 1'b1;
    req_boot  = 1'b0;
    push_seq(1'b0);
    @(negedge clk);
    req_valid = 1'b0;
    req_boot  = 1'b1;
    wait_drain();
    repeat (3) @(negedge clk);

    // req_valid held high with req_boot wiggling; re-accept on the ready cycle.
    scn = "b2b";
    req_valid = 1'b1;
    req_boot  = 1'b1;
    push_seq(1'b1);
    push_seq(1'b0);
    for (int i = 0; i < TOTAL - 1; i++) begin
      @(negedge clk);
      req_boot = (i % 2 == 0) ? 1'b0 : 1'(($urandom_range(0, 1)));
    end
    @(negedge clk);
    req_boot = 1'b0;
    @(negedge clk);
    req_valid = 1'b0;
    wait_drain();
    repeat (3) @(negedge clk);

    // Reset asserted mid STRAP_HOLD in boot mode.
    scn = "rstmid";
    req_valid = 1'b1;
    req_boot  = 1'b1;
    push_seq(1'b1);
    @(negedge clk);
    req_valid = 1'b0;
    req_boot  = 1'b0;
    repeat (4) @(negedge clk);
    mon_en = 1'b0;
    rst_n  = 1'b0;
    #1;
    check_all(IDLE_EXP);
    exp_q.delete();
    @(negedge clk);
    check_all(IDLE_EXP);
    rst_n  = 1'b1;
    mon_en = 1'b1;
    scn = "post";
    repeat (5) @(negedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
